// File: rtl/mchan_cmd_arbiter_if.sv
// Command handshake bundle between the MCHAN control front-ends and the command-queue arbiter.
// The slave modport is the arbiter's view; the master modport is the front-end/queue side.
interface mchan_cmd_arbiter_if #(
    parameter int NB_PORTS  = 4,
    parameter int CMD_WIDTH = 64
);
    localparam int PORT_ID_WIDTH = (NB_PORTS == 1) ? 1 : $clog2(NB_PORTS);

    logic [NB_PORTS-1:0]           in_req_i;
    logic [NB_PORTS-1:0]           in_gnt_o;
    logic [NB_PORTS*CMD_WIDTH-1:0] in_data_i;
    logic [NB_PORTS-1:0]           in_lock_i;
    logic                          out_req_o;
    logic                          out_gnt_i;
    logic [CMD_WIDTH-1:0]          out_data_o;
    logic [PORT_ID_WIDTH-1:0]      out_port_o;

    modport slave (
        input  in_req_i, in_data_i, in_lock_i, out_gnt_i,
        output in_gnt_o, out_req_o, out_data_o, out_port_o
    );

    modport master (
        output in_req_i, in_data_i, in_lock_i, out_gnt_i,
        input  in_gnt_o, out_req_o, out_data_o, out_port_o
    );
endinterface

// File: rtl/mchan_cmd_arbiter.sv
// Round-robin command arbiter with lock support and a 1-deep registered output stage.
// Optional feature macro: MCHAN_ARB_STATS_EN enables per-port saturating accept counters.
module mchan_cmd_arbiter #(
    parameter  int NB_PORTS      = 4,
    parameter  int CMD_WIDTH     = 64,
    localparam int PORT_ID_WIDTH = (NB_PORTS == 1) ? 1 : $clog2(NB_PORTS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    mchan_cmd_arbiter_if.slave       bus,
    output logic                     busy_o,
    input  logic                     stat_clr_i,
    output logic [NB_PORTS*16-1:0]   stat_cnt_o
);
    localparam int SUM_W = PORT_ID_WIDTH + 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                   state_q, state_d;
    logic [PORT_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [PORT_ID_WIDTH-1:0] owner_q, owner_d;
    logic                     out_req_q, out_req_d;
    logic [CMD_WIDTH-1:0]     out_data_q, out_data_d;
    logic [PORT_ID_WIDTH-1:0] out_port_q, out_port_d;

    logic [CMD_WIDTH-1:0]     in_data [NB_PORTS];
    logic [NB_PORTS-1:0]      in_gnt;
    logic                     stage_free;
    logic                     win_vld;
    logic [PORT_ID_WIDTH-1:0] win_idx;
    logic [SUM_W-1:0]         cand;
    logic [PORT_ID_WIDTH-1:0] cand_idx;
    logic                     accept;

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_unpack
        assign in_data[p] = bus.in_data_i[p*CMD_WIDTH +: CMD_WIDTH];
    end

    assign stage_free = !out_req_q || bus.out_gnt_i;

    // Winner: locked owner only, otherwise first requester at or after the pointer.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = '0;
        cand_idx = '0;
        if (state_q == LOCKED) begin
            if (bus.in_req_i[owner_q]) begin
                win_vld = 1'b1;
                win_idx = owner_q;
            end
        end else begin
            for (int i = 0; i < NB_PORTS; i++) begin
                cand = {1'b0, ptr_q} + SUM_W'(i);
                if (cand >= SUM_W'(NB_PORTS)) begin
                    cand = cand - SUM_W'(NB_PORTS);
                end
                cand_idx = cand[PORT_ID_WIDTH-1:0];
                if (!win_vld && bus.in_req_i[cand_idx]) begin
                    win_vld = 1'b1;
                    win_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        in_gnt = '0;
        if (stage_free && win_vld) begin
            in_gnt[win_idx] = 1'b1;
        end
    end

    assign accept = |in_gnt;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        out_port_d = out_port_q;
        if (out_req_q && bus.out_gnt_i) begin
            out_req_d = 1'b0;
        end
        if (accept) begin
            out_req_d  = 1'b1;
            out_data_d = in_data[win_idx];
            out_port_d = win_idx;
            if (bus.in_lock_i[win_idx]) begin
                state_d = LOCKED;
                owner_d = win_idx;
            end else begin
                state_d = IDLE;
                ptr_d   = (win_idx == PORT_ID_WIDTH'(NB_PORTS - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            out_port_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
            out_port_q <= out_port_d;
        end
    end

    assign bus.in_gnt_o   = in_gnt;
    assign bus.out_req_o  = out_req_q;
    assign bus.out_data_o = out_data_q;
    assign bus.out_port_o = out_port_q;
    assign busy_o         = out_req_q || (state_q == LOCKED) || (|bus.in_req_i);

`ifdef MCHAN_ARB_STATS_EN
    logic [15:0] cnt_q [NB_PORTS];
    logic [15:0] cnt_d [NB_PORTS];

    // Clear takes priority over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        for (int p = 0; p < NB_PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (stat_clr_i) begin
                cnt_d[p] = '0;
            end else if (in_gnt[p] && cnt_q[p] != 16'hFFFF) begin
                cnt_d[p] = cnt_q[p] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NB_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NB_PORTS; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_stat
        assign stat_cnt_o[p*16 +: 16] = cnt_q[p];
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr_i;
    assign stat_cnt_o      = '0;
`endif
endmodule
